// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Forwarding selects, FSM state codes and register-index width.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_LSTALL = 2'b01;
  localparam logic [1:0] ST_MWAIT  = 2'b10;

endpackage

// File: rtl/fwd_match.sv
// Per-operand hazard compare: ID source reg against EX/MEM destinations.
// Produces the next forwarding select and a load-use hit flag.
module fwd_match #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_use,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_we,
  input  logic             i_ex_load,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_we,
  output logic [1:0]       o_fwd_nxt,
  output logic             o_load_hit
);
  import pipe_pkg::*;

  logic w_valid;
  logic w_ex_hit;
  logic w_mem_hit;

  // x0 is hardwired zero: never a hazard
  assign w_valid   = i_use && (i_rs != '0);
  assign w_ex_hit  = w_valid && (i_rs == i_ex_rd) && i_ex_we;
  assign w_mem_hit = w_valid && (i_rs == i_mem_rd) && i_mem_we;

  assign o_load_hit = w_ex_hit && i_ex_load;

  always_comb begin
    o_fwd_nxt = FWD_RF;
    if (w_ex_hit && !i_ex_load)
      o_fwd_nxt = FWD_EXMEM;
    else if (w_mem_hit)
      o_fwd_nxt = FWD_MEMWB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipeline.
// Orders memory wait > branch redirect > load-use bubble.
module pipeline_ctrl #(
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_we,
  input  logic             ex_load,
  input  logic             ex_br_taken,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_pkg::*;

  logic [1:0]       r_state;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0] w_state_nxt;
  logic [1:0] w_fwd_a_nxt;
  logic [1:0] w_fwd_b_nxt;
  logic       w_hit_a;
  logic       w_hit_b;
  logic       w_mem_stall;
  logic       w_branch;
  logic       w_bubble;
  logic       w_pc_en;
  logic       w_if_id_en;
  logic       w_if_id_flush;
  logic       w_id_ex_en;
  logic       w_id_ex_flush;
  logic       w_ex_mem_en;
  logic       w_mem_wb_flush;

  fwd_match #(.REG_W(REG_W)) u_fwd_a (
    .i_rs      (id_rs1),
    .i_use     (id_use_rs1),
    .i_ex_rd   (ex_rd),
    .i_ex_we   (ex_we),
    .i_ex_load (ex_load),
    .i_mem_rd  (mem_rd),
    .i_mem_we  (mem_we),
    .o_fwd_nxt (w_fwd_a_nxt),
    .o_load_hit(w_hit_a)
  );

  fwd_match #(.REG_W(REG_W)) u_fwd_b (
    .i_rs      (id_rs2),
    .i_use     (id_use_rs2),
    .i_ex_rd   (ex_rd),
    .i_ex_we   (ex_we),
    .i_ex_load (ex_load),
    .i_mem_rd  (mem_rd),
    .i_mem_we  (mem_we),
    .o_fwd_nxt (w_fwd_b_nxt),
    .o_load_hit(w_hit_b)
  );

  // While waiting, only mem_ready matters; the request is already latched
  assign w_mem_stall = (r_state == ST_MWAIT) ? !mem_ready
                                             : (mem_req && !mem_ready);
  assign w_branch    = ex_br_taken && !w_mem_stall;
  assign w_bubble    = (w_hit_a || w_hit_b) && (r_state != ST_LSTALL)
                    && !ex_br_taken && !w_mem_stall;

  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_en     = 1'b1;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_flush = 1'b0;
    w_state_nxt    = ST_RUN;
    unique case (1'b1)
      w_mem_stall: begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_flush = 1'b1;
        w_state_nxt    = ST_MWAIT;
      end
      w_branch: begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end
      w_bubble: begin
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_id_ex_flush = 1'b1;
        w_state_nxt   = ST_LSTALL;
      end
      default: ;
    endcase
  end

  assign pc_en        = rst_n && w_pc_en;
  assign if_id_en     = rst_n && w_if_id_en;
  assign if_id_flush  = !rst_n || w_if_id_flush;
  assign id_ex_en     = rst_n && w_id_ex_en;
  assign id_ex_flush  = !rst_n || w_id_ex_flush;
  assign ex_mem_en    = rst_n && w_ex_mem_en;
  assign mem_wb_flush = !rst_n || w_mem_wb_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (w_id_ex_flush) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (w_id_ex_en) begin
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!w_pc_en && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand sequences for
// async reset and counter saturation, then a randomized model comparison.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  // action bits: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, mwb_fl}
  localparam logic [6:0] ADV = 7'b1101010;
  localparam logic [6:0] RED = 7'b1111110;
  localparam logic [6:0] BUB = 7'b0001110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] RST = 7'b0010101;

  typedef struct packed {
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] exrd;
    logic       exwe;
    logic       exld;
    logic       br;
    logic [4:0] mrd;
    logic       mwe;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct {
    in_t         i;
    logic [14:0] e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
  logic          id_use_rs1, id_use_rs2, ex_we, ex_load, ex_br_taken;
  logic          mem_we, mem_req, mem_ready;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, mem_wb_flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl #(.REG_W(5), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_we       (ex_we),
    .ex_load     (ex_load),
    .ex_br_taken (ex_br_taken),
    .mem_rd      (mem_rd),
    .mem_we      (mem_we),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_flush(mem_wb_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(int rs1, int u1, int rs2, int u2,
                             int exrd, int exwe, int exld, int br,
                             int mrd, int mwe, int mreq, int mrdy);
    in_t x;
    x.rs1 = 5'(rs1); x.u1 = 1'(u1);
    x.rs2 = 5'(rs2); x.u2 = 1'(u2);
    x.exrd = 5'(exrd); x.exwe = 1'(exwe); x.exld = 1'(exld);
    x.br = 1'(br);
    x.mrd = 5'(mrd); x.mwe = 1'(mwe);
    x.mreq = 1'(mreq); x.mrdy = 1'(mrdy);
    return x;
  endfunction

  function automatic logic [14:0] ex(logic [6:0] act, int fa, int fb,
                                     int cnt);
    return {act, 2'(fa), 2'(fb), 4'(cnt)};
  endfunction

  task automatic apply(input in_t x);
    id_rs1 = x.rs1; id_use_rs1 = x.u1;
    id_rs2 = x.rs2; id_use_rs2 = x.u2;
    ex_rd = x.exrd; ex_we = x.exwe; ex_load = x.exld;
    ex_br_taken = x.br;
    mem_rd = x.mrd; mem_we = x.mwe;
    mem_req = x.mreq; mem_ready = x.mrdy;
  endtask

  task automatic chk(input string name, input logic [14:0] exp);
    logic [14:0] got;
    got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_flush, fwd_a_sel, fwd_b_sel, stall_cnt};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b_%b_%b_%h required=%b_%b_%b_%h", name,
               got[14:8], got[7:6], got[5:4], got[3:0],
               exp[14:8], exp[7:6], exp[5:4], exp[3:0]);
    end
  endtask

  // Reference model: spec rules stated as actions per cycle
  bit         m_wait, m_bub;
  logic [1:0] m_fa, m_fb;
  int         m_cnt;

  function automatic logic [1:0] fsel(logic [4:0] rs, logic u, in_t x);
    if (!u || rs == 5'd0) return 2'b00;
    if (rs == x.exrd && x.exwe && !x.exld) return 2'b01;
    if (rs == x.mrd && x.mwe) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit lhit(logic [4:0] rs, logic u, in_t x);
    return u && rs != 5'd0 && rs == x.exrd && x.exwe && x.exld;
  endfunction

  function automatic logic [6:0] model_act(in_t x);
    bit frz, lu;
    frz = m_wait ? !x.mrdy : (x.mreq && !x.mrdy);
    lu  = lhit(x.rs1, x.u1, x) || lhit(x.rs2, x.u2, x);
    if (frz) return FRZ;
    if (x.br) return RED;
    if (lu && !m_bub) return BUB;
    return ADV;
  endfunction

  vec_t tbl[16];
  in_t  idle;
  in_t  wt;
  in_t  rx;
  logic [6:0] act;

  initial begin
    idle = mi(0,0,0,0, 0,0,0,0, 0,0,0,1);
    wt   = mi(0,0,0,0, 0,0,0,0, 0,0,1,0);

    tbl[0]  = '{mi(5,1,0,0, 5,1,0,0, 0,0,0,1), ex(ADV,0,0,0)};
    tbl[1]  = '{idle,                          ex(ADV,1,0,0)};
    tbl[2]  = '{mi(0,0,7,1, 7,1,1,0, 0,0,0,1), ex(BUB,0,0,0)};
    tbl[3]  = '{mi(0,0,7,1, 0,0,0,0, 7,1,0,1), ex(ADV,0,0,1)};
    tbl[4]  = '{mi(0,1,0,1, 0,1,1,0, 0,1,0,1), ex(ADV,0,2,1)};
    tbl[5]  = '{mi(3,1,0,0, 3,1,1,1, 0,0,0,1), ex(RED,0,0,1)};
    tbl[6]  = '{mi(9,1,9,1, 9,1,0,0, 9,1,0,1), ex(ADV,0,0,1)};
    tbl[7]  = '{mi(4,1,0,0, 0,0,0,0, 4,1,1,0), ex(FRZ,1,1,1)};
    tbl[8]  = '{wt,                            ex(FRZ,1,1,2)};
    tbl[9]  = '{wt,                            ex(FRZ,1,1,3)};
    tbl[10] = '{mi(0,0,0,0, 0,0,0,1, 0,0,1,1), ex(RED,1,1,4)};
    tbl[11] = '{idle,                          ex(ADV,0,0,4)};
    tbl[12] = '{wt,                            ex(FRZ,0,0,4)};
    tbl[13] = '{mi(6,1,0,0, 6,1,0,0, 0,0,1,1), ex(ADV,0,0,5)};
    tbl[14] = '{idle,                          ex(ADV,1,0,5)};
    tbl[15] = '{wt,                            ex(FRZ,0,0,5)};

    rst_n = 1'b0;
    apply(idle);
    #2 chk("reset", ex(RST,0,0,0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      apply(tbl[k].i);
      #2 chk($sformatf("vec%0d", k), tbl[k].e);
    end

    // async reset while frozen in memory wait
    @(negedge clk);
    apply(wt);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_wait", ex(RST,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(mi(0,0,0,0, 0,0,0,0, 0,0,0,0));
    #2 chk("rst_release_run", ex(ADV,0,0,0));

    // stall counter saturation
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      apply(wt);
    end
    @(negedge clk);
    #2 chk("cnt_saturate", ex(FRZ,0,0,15));
    @(negedge clk);
    apply(idle);
    #2 chk("cnt_hold_sat", ex(ADV,0,0,15));

    // randomized run against the model
    @(negedge clk);
    rst_n = 1'b0;
    apply(idle);
    @(negedge clk);
    rst_n = 1'b1;
    m_wait = 0; m_bub = 0; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rx.rs1  = 5'($urandom_range(0, 3));
      rx.u1   = 1'($urandom_range(0, 1));
      rx.rs2  = 5'($urandom_range(0, 3));
      rx.u2   = 1'($urandom_range(0, 1));
      rx.exrd = 5'($urandom_range(0, 3));
      rx.exwe = ($urandom_range(0, 9) < 7);
      rx.exld = ($urandom_range(0, 9) < 3);
      rx.br   = ($urandom_range(0, 9) < 1);
      rx.mrd  = 5'($urandom_range(0, 3));
      rx.mwe  = ($urandom_range(0, 9) < 6);
      rx.mreq = ($urandom_range(0, 9) < 3);
      rx.mrdy = ($urandom_range(0, 9) < 6);
      apply(rx);
      act = model_act(rx);
      #2 chk($sformatf("rand%0d", n), {act, m_fa, m_fb, 4'(m_cnt)});
      @(posedge clk);
      m_wait = (act == FRZ);
      m_bub  = (act == BUB);
      if (act[2]) begin
        m_fa = 2'b00; m_fb = 2'b00;
      end else if (act[3]) begin
        m_fa = fsel(rx.rs1, rx.u1, rx);
        m_fb = fsel(rx.rs2, rx.u2, rx);
      end
      if (!act[6] && m_cnt < 15) m_cnt++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
